// File: rtl/acc_requant_stream.sv
// acc_requant_stream
//   Readout stage for the systolic FP4xINT8 array. Takes the serial stream of
//   signed accumulator results and requantizes each one to signed INT8:
//   arithmetic right shift, optional round-half-up, optional ReLU, saturation.
//   One frame is one matrix tile of N_VALUES results, armed by a start pulse.
//   Saturation events are counted per frame (sticky at 255).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse: latch cfg_*, clear counters, arm frame
//   cfg_shift           right-shift amount (0..ACC_W-1)
//   cfg_round           add 2^(shift-1) before shifting
//   cfg_relu            clamp negative results to zero
//   in_valid/in_ready   input stream handshake, in_data = accumulator value
//   out_valid/out_ready output stream handshake, out_data = INT8 result
//   out_last            marks the final byte of the frame
//   busy                frame in progress
//   done                one-cycle pulse after the final output handshake
//   sat_count           saturation events of the current/last frame
module acc_requant_stream #(
    parameter int ACC_W    = 24,
    parameter int N_VALUES = 32,
    parameter int SHIFT_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_round,
    input  logic               cfg_relu,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [7:0]         sat_count
);

    localparam int CNT_W = $clog2(N_VALUES + 1);

    localparam logic signed [ACC_W:0] MAX_I8 = 127;
    localparam logic signed [ACC_W:0] MIN_I8 = -128;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [SHIFT_W-1:0] shift_q;
    logic               round_q;
    logic               relu_q;
    logic [CNT_W-1:0]   in_count;
    logic [CNT_W-1:0]   out_count;

    logic                    vld_p1;
    logic signed [ACC_W:0]   data_p1;

    logic adv_p1;
    logic adv_p2;
    logic in_fire;
    logic out_fire;
    logic [8:0] req_p1;

    // Sign-extend by one bit so the rounding bias can never overflow, then
    // add the half-LSB bias (if enabled) and shift arithmetically.
    function automatic logic signed [ACC_W:0] shift_round(
        input logic [ACC_W-1:0]   v,
        input logic [SHIFT_W-1:0] sh,
        input logic               rnd
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] bias;
        ext  = {v[ACC_W-1], v};
        bias = '0;
        if (rnd && sh != '0) begin
            bias[sh - SHIFT_W'(1)] = 1'b1;
        end
        shift_round = (ext + bias) >>> sh;
    endfunction

    // Returns {clamped, byte}. ReLU is applied first so that zeroing a
    // negative value never registers as a saturation event.
    function automatic logic [8:0] relu_sat(
        input logic signed [ACC_W:0] v,
        input logic                  relu
    );
        logic signed [ACC_W:0] r;
        r = (relu && v < 0) ? '0 : v;
        if (r > MAX_I8) begin
            relu_sat = {1'b1, 8'h7F};
        end else if (r < MIN_I8) begin
            relu_sat = {1'b1, 8'h80};
        end else begin
            relu_sat = {1'b0, r[7:0]};
        end
    endfunction

    // A stage may load when it is empty or its contents are leaving.
    assign adv_p2   = !out_valid || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = (state == RUN) && (in_count < CNT_W'(N_VALUES)) && adv_p1;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_last = out_valid && (out_count == CNT_W'(N_VALUES - 1));
    assign busy     = (state == RUN);
    assign req_p1   = relu_sat(data_p1, relu_q);

    // ---- stage p1: shift / round ----
    always_ff @(posedge clk) begin
        if (adv_p1 && in_fire) begin
            data_p1 <= shift_round(in_data, shift_q, round_q);
        end
    end

    // ---- control, stage p2 output register, counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            round_q   <= 1'b0;
            relu_q    <= 1'b0;
            in_count  <= '0;
            out_count <= '0;
            sat_count <= '0;
            done      <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q   <= cfg_shift;
                        round_q   <= cfg_round;
                        relu_q    <= cfg_relu;
                        in_count  <= '0;
                        out_count <= '0;
                        sat_count <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_count <= in_count + CNT_W'(1);
                    end
                    if (out_fire) begin
                        out_count <= out_count + CNT_W'(1);
                        if (out_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (adv_p1) begin
                vld_p1 <= in_fire;
            end

            if (adv_p2) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    out_data <= req_p1[7:0];
                    if (req_p1[8] && sat_count != 8'hFF) begin
                        sat_count <= sat_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_requant_stream.sv
module tb_acc_requant_stream;

    localparam int N  = 32;
    localparam int NB = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, cfg_round, cfg_relu, in_valid, out_ready;
    logic [4:0]  cfg_shift;
    logic [23:0] in_data;
    logic        in_ready, out_valid, out_last, busy, done;
    logic [7:0]  out_data, sat_count;

    logic        b_start, b_cfg_round, b_cfg_relu, b_in_valid, b_out_ready;
    logic [4:0]  b_cfg_shift;
    logic [23:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
    logic [7:0]  b_out_data, b_sat_count;

    acc_requant_stream #(.ACC_W(24), .N_VALUES(N), .SHIFT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_shift(cfg_shift),
        .cfg_round(cfg_round), .cfg_relu(cfg_relu), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .sat_count(sat_count)
    );

    acc_requant_stream #(.ACC_W(24), .N_VALUES(NB), .SHIFT_W(5)) dut_big (
        .clk(clk), .reset(reset), .start(b_start), .cfg_shift(b_cfg_shift),
        .cfg_round(b_cfg_round), .cfg_relu(b_cfg_relu), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .busy(b_busy), .done(b_done), .sat_count(b_sat_count)
    );

    int total = 0;
    int bad   = 0;

    int         vals[$];
    logic [7:0] got[$];
    int r_lasts, r_last_idx, r_stable_bad, r_done_gap, r_lat, r_ir_after, r_busy_bad;
    bit r_timeout;
    logic r_done_after;

    // Reference: exact rational arithmetic with floor division.
    function automatic logic [7:0] model_byte(input int v, input int sh, input bit rnd,
                                              input bit relu, output bit sat);
        longint x, p, q;
        p = 64'sd1 << sh;
        x = v;
        if (rnd && sh > 0) x = x + p / 2;
        q = x / p;
        if (x < 0 && q * p != x) q = q - 1;
        if (relu && q < 0) q = 0;
        sat = 1'b0;
        if (q > 127) begin q = 127; sat = 1'b1; end
        else if (q < -128) begin q = -128; sat = 1'b1; end
        return q[7:0];
    endfunction

    function automatic int rand_acc();
        logic [31:0] r;
        r = $urandom;
        return int'({{8{r[23]}}, r[23:0]});
    endfunction

    task automatic run_frame(input int sh, input bit rnd, input bit relu,
                             input bit rand_rdy, input bit gaps, input int poke_at);
        int ni, first_in, first_out, hs_last, tmp;
        bit p_stall;
        logic [7:0] p_data;
        logic p_last;
        got.delete();
        r_lasts = 0; r_last_idx = -1; r_stable_bad = 0; r_done_gap = -1;
        r_ir_after = 0; r_busy_bad = 0; r_timeout = 1'b1;
        first_in = -1; first_out = -1; hs_last = -1; p_stall = 1'b0;
        p_data = '0; p_last = 1'b0; ni = 0;
        @(posedge clk); #1;
        cfg_shift = sh[4:0]; cfg_round = rnd; cfg_relu = relu;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = (cyc == poke_at);
            if (cyc == poke_at) begin
                cfg_shift = ~cfg_shift; cfg_round = ~cfg_round; cfg_relu = ~cfg_relu;
            end
            in_valid = (ni < N) && (!gaps || $urandom_range(0, 2) != 0);
            tmp = (ni < N) ? vals[ni] : 0;
            in_data = tmp[23:0];
            out_ready = !rand_rdy || ($urandom_range(0, 2) == 0);
            #1;
            if (done) begin
                r_done_gap = cyc - hs_last;
                r_timeout = 1'b0;
                if (busy) r_busy_bad++;
                break;
            end
            if (p_stall && (!out_valid || out_data !== p_data || out_last !== p_last))
                r_stable_bad++;
            if (ni >= N && in_ready) r_ir_after++;
            if (out_valid && first_out < 0) first_out = cyc;
            if (in_valid && in_ready) begin
                if (first_in < 0) first_in = cyc;
                ni++;
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last) begin
                    r_lasts++;
                    r_last_idx = got.size() - 1;
                    hs_last = cyc;
                end
            end
            p_stall = out_valid && !out_ready;
            p_data = out_data;
            p_last = out_last;
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        r_lat = first_out - first_in;
        @(posedge clk); #1;
        r_done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; cfg_shift = 0; cfg_round = 0; cfg_relu = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        b_start = 0; b_cfg_shift = 0; b_cfg_round = 0; b_cfg_relu = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset out_data got=%h want=00", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last got=%b want=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
        total++; if (sat_count !== 8'h00) begin bad++; $display("FAIL reset sat_count got=%h want=00", sat_count); end
    endtask

    task automatic test_shift11();
        logic [7:0] e, lit[4];
        bit s;
        int sc;
        lit[0] = 8'h01; lit[1] = 8'hFF; lit[2] = 8'h7F; lit[3] = 8'h80;
        vals.delete();
        vals.push_back(2048); vals.push_back(-2048);
        vals.push_back(32'h007FFFFF); vals.push_back(-8388608);
        while (vals.size() < N) vals.push_back(int'($urandom_range(0, 520192)) - 260096);
        run_frame(11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        total++; if (got.size() != N) begin bad++; $display("FAIL shift11 count got=%0d want=%0d", got.size(), N); end
        sc = 0;
        for (int i = 0; i < N; i++) begin
            e = model_byte(vals[i], 11, 1'b0, 1'b0, s);
            if (s) sc++;
            total++;
            if (i >= got.size() || got[i] !== e) begin
                bad++; $display("FAIL shift11 byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got.size() || got[i] !== lit[i]) begin
                bad++; $display("FAIL shift11 lit%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, lit[i]);
            end
        end
        total++; if (sat_count !== 8'd2 || sc != 2) begin bad++; $display("FAIL shift11 sat_count got=%0d want=2", sat_count); end
        total++; if (r_lat != 2) begin bad++; $display("FAIL shift11 latency got=%0d want=2", r_lat); end
        total++; if (r_timeout || r_done_gap != 1) begin bad++; $display("FAIL shift11 done_gap got=%0d want=1", r_done_gap); end
        total++; if (r_done_after !== 1'b0) begin bad++; $display("FAIL shift11 done_width got=%b want=0", r_done_after); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (sat_count !== 8'd2) begin bad++; $display("FAIL shift11 sat_hold got=%0d want=2", sat_count); end
    endtask

    task automatic test_round();
        logic [7:0] e, lit[4];
        bit s;
        lit[0] = 8'h02; lit[1] = 8'hFF; lit[2] = 8'h01; lit[3] = 8'h00;
        vals.delete();
        vals.push_back(3); vals.push_back(-3); vals.push_back(1); vals.push_back(-1);
        while (vals.size() < N) vals.push_back(int'($urandom_range(0, 600)) - 300);
        run_frame(1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        total++; if (got.size() != N) begin bad++; $display("FAIL round count got=%0d want=%0d", got.size(), N); end
        for (int i = 0; i < N; i++) begin
            e = model_byte(vals[i], 1, 1'b1, 1'b0, s);
            total++;
            if (i >= got.size() || got[i] !== e) begin
                bad++; $display("FAIL round byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got.size() || got[i] !== lit[i]) begin
                bad++; $display("FAIL round lit%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, lit[i]);
            end
        end
    endtask

    task automatic test_relu();
        logic [7:0] e, lit[3];
        bit s;
        lit[0] = 8'h00; lit[1] = 8'h64; lit[2] = 8'h7F;
        vals.delete();
        vals.push_back(-5000); vals.push_back(100); vals.push_back(300);
        while (vals.size() < N) vals.push_back(int'($urandom_range(0, 200)) - 100);
        run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        total++; if (got.size() != N) begin bad++; $display("FAIL relu count got=%0d want=%0d", got.size(), N); end
        for (int i = 0; i < N; i++) begin
            e = model_byte(vals[i], 0, 1'b0, 1'b1, s);
            total++;
            if (i >= got.size() || got[i] !== e) begin
                bad++; $display("FAIL relu byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= got.size() || got[i] !== lit[i]) begin
                bad++; $display("FAIL relu lit%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, lit[i]);
            end
        end
        total++; if (sat_count !== 8'd1) begin bad++; $display("FAIL relu sat_count got=%0d want=1", sat_count); end
    endtask

    task automatic test_back_to_back(input int poke_at);
        logic [7:0] e;
        bit s;
        int sh, sc;
        bit rnd, relu;
        sh = $urandom_range(0, 23); rnd = 1'($urandom); relu = 1'($urandom);
        vals.delete();
        while (vals.size() < N) vals.push_back(rand_acc());
        run_frame(sh, rnd, relu, 1'b1, 1'b1, poke_at);
        total++; if (got.size() != N) begin bad++; $display("FAIL b2b count got=%0d want=%0d", got.size(), N); end
        sc = 0;
        for (int i = 0; i < N; i++) begin
            e = model_byte(vals[i], sh, rnd, relu, s);
            if (s && sc < 255) sc++;
            total++;
            if (i >= got.size() || got[i] !== e) begin
                bad++; $display("FAIL b2b byte%0d sh=%0d got=%h want=%h", i, sh, (i < got.size()) ? got[i] : 8'hxx, e);
            end
        end
        total++; if (sat_count !== 8'(sc)) begin bad++; $display("FAIL b2b sat_count got=%0d want=%0d", sat_count, sc); end
        total++; if (r_stable_bad != 0) begin bad++; $display("FAIL b2b stall_stability got=%0d want=0", r_stable_bad); end
        total++; if (r_lasts != 1 || r_last_idx != N - 1) begin bad++; $display("FAIL b2b out_last got=%0d@%0d want=1@%0d", r_lasts, r_last_idx, N - 1); end
        total++; if (r_timeout || r_done_gap != 1) begin bad++; $display("FAIL b2b done_gap got=%0d want=1", r_done_gap); end
        total++; if (r_busy_bad != 0) begin bad++; $display("FAIL b2b busy_at_done got=%0d want=0", r_busy_bad); end
        total++; if (r_ir_after != 0) begin bad++; $display("FAIL b2b in_ready_after_last got=%0d want=0", r_ir_after); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        cfg_shift = 0; cfg_round = 0; cfg_relu = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 24'h7FFFFF; out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || sat_count !== 8'd1) begin bad++; $display("FAIL midrst pre got=%b/%0d want=1/1", out_valid, sat_count); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL midrst out_data got=%h want=00", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst busy got=%b want=0", busy); end
        total++; if (sat_count !== 8'h00) begin bad++; $display("FAIL midrst sat_count got=%0d want=0", sat_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst in_ready got=%b want=0", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL midrst activity got=1 want=0"); end
    endtask

    task automatic test_sticky();
        int nbytes, badbytes;
        bit seen_done;
        @(posedge clk); #1;
        b_cfg_shift = 0; b_cfg_round = 0; b_cfg_relu = 0; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0; b_in_valid = 1'b1; b_in_data = 24'h7FFFFF; b_out_ready = 1'b1;
        nbytes = 0; badbytes = 0; seen_done = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            #1;
            if (b_done) begin seen_done = 1'b1; break; end
            if (b_out_valid && b_out_ready) begin
                nbytes++;
                if (b_out_data !== 8'h7F) badbytes++;
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        total++; if (!seen_done) begin bad++; $display("FAIL sticky done got=0 want=1"); end
        total++; if (nbytes != NB || badbytes != 0) begin bad++; $display("FAIL sticky bytes got=%0d(bad %0d) want=%0d", nbytes, badbytes, NB); end
        total++; if (b_sat_count !== 8'd255) begin bad++; $display("FAIL sticky sat_count got=%0d want=255", b_sat_count); end
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        total++; if (b_sat_count !== 8'd0 || b_busy !== 1'b1) begin bad++; $display("FAIL sticky restart got=%0d/%b want=0/1", b_sat_count, b_busy); end
    endtask

    initial begin
        test_reset();
        test_shift11();
        test_round();
        test_relu();
        test_back_to_back(-1);
        test_back_to_back(-1);
        test_back_to_back(7);
        test_reset_mid();
        test_back_to_back(-1);
        test_sticky();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
